// File: rtl/video_pattern_gen.sv
// video_pattern_gen: parametrised raster timing and test-pattern source.
// Ports: clk_pix, rst_n (async, active-low), mode_in[2:0] -> sx, sy, de,
//   hsync, vsync, frame_start, rgb {R,G,B}; all registered, 1 clk after cx/cy.
// Option: define VIDEO_PATTERN_BORDER_EN for a white 1-pixel border
//   drawn over every mode except black.
module video_pattern_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CORDW    = 10,
   parameter int COLW     = 8,
   parameter int Q_SIZE   = 32,
   parameter int Q_SPEED  = 4
) (
   input  logic              clk_pix,
   input  logic              rst_n,
   input  logic [2:0]        mode_in,
   output logic [CORDW-1:0]  sx,
   output logic [CORDW-1:0]  sy,
   output logic              de,
   output logic              hsync,
   output logic              vsync,
   output logic              frame_start,
   output logic [3*COLW-1:0] rgb
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [CORDW-1:0] H_A  = CORDW'(H_ACTIVE);
   localparam logic [CORDW-1:0] H_L  = CORDW'(H_TOTAL - 1);
   localparam logic [CORDW-1:0] HS_S = CORDW'(H_ACTIVE + H_FP);
   localparam logic [CORDW-1:0] HS_L = CORDW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CORDW-1:0] V_A  = CORDW'(V_ACTIVE);
   localparam logic [CORDW-1:0] V_L  = CORDW'(V_TOTAL - 1);
   localparam logic [CORDW-1:0] VS_S = CORDW'(V_ACTIVE + V_FP);
   localparam logic [CORDW-1:0] VS_L = CORDW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [CORDW-1:0] BW   = CORDW'(BAR_W);

   // One extra bit so q+speed and q+size never wrap.
   localparam logic [CORDW:0] QS   = (CORDW+1)'(Q_SIZE);
   localparam logic [CORDW:0] QV   = (CORDW+1)'(Q_SPEED);
   localparam logic [CORDW:0] LIMX = (CORDW+1)'(H_ACTIVE - Q_SIZE);
   localparam logic [CORDW:0] LIMY = (CORDW+1)'(V_ACTIVE - Q_SIZE);

   logic [CORDW-1:0] cx, cy;
   logic [CORDW-1:0] qx, qy;
   logic             dx_neg, dy_neg;
   logic [2:0]       mode_q, mode_e;
   logic             origin;

   logic             de_c, hs_c, vs_c, in_sq;
   logic [7:0]       x8, y8;
   logic [2:0]       bar;
   logic [COLW-1:0]  r, g, b;

   function automatic logic [COLW-1:0] ext(input logic [7:0] v);
      return COLW'(v) << (COLW - 8);
   endfunction

   // Returns {dir_neg, q} after one animation step on one axis.
   function automatic logic [CORDW:0] bounce(
      input logic [CORDW-1:0] q,
      input logic             neg,
      input logic [CORDW:0]   lim
   );
      logic [CORDW:0] qe, nq;
      logic           nn;
      qe = {1'b0, q};
      nq = qe;
      nn = neg;
      if (!neg) begin
         if (qe + QV > lim) begin
            nq = lim;
            nn = 1'b1;
         end else begin
            nq = qe + QV;
         end
      end else begin
         if (qe < QV) begin
            nq = '0;
            nn = 1'b0;
         end else begin
            nq = qe - QV;
         end
      end
      return {nn, nq[CORDW-1:0]};
   endfunction

   assign origin = (cx == '0) && (cy == '0);
   // The frame-start pixel already uses the newly latched mode.
   assign mode_e = origin ? mode_in : mode_q;

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         cx <= '0;
         cy <= '0;
      end else if (cx == H_L) begin
         cx <= '0;
         cy <= (cy == V_L) ? '0 : cy + 1'b1;
      end else begin
         cx <= cx + 1'b1;
      end
   end

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         mode_q <= '0;
      end else if (origin) begin
         mode_q <= mode_in;
      end
   end

   // Square moves once per frame, just after the last active line.
   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         qx     <= '0;
         qy     <= '0;
         dx_neg <= 1'b0;
         dy_neg <= 1'b0;
      end else if (cx == '0 && cy == V_A) begin
         {dx_neg, qx} <= bounce(qx, dx_neg, LIMX);
         {dy_neg, qy} <= bounce(qy, dy_neg, LIMY);
      end
   end

   always_comb begin
      de_c  = (cx < H_A) && (cy < V_A);
      hs_c  = (cx >= HS_S) && (cx <= HS_L);
      vs_c  = (cy >= VS_S) && (cy <= VS_L);
      x8    = 8'(cx);
      y8    = 8'(cy);
      bar   = 3'(cx / BW);
      in_sq = ({1'b0, cx} >= {1'b0, qx}) &&
              ({1'b0, cx} <  {1'b0, qx} + QS) &&
              ({1'b0, cy} >= {1'b0, qy}) &&
              ({1'b0, cy} <  {1'b0, qy} + QS);
      r = '0;
      g = '0;
      b = '0;
      unique case (1'b1)
         (mode_e == 3'd1): begin
            // W,Y,C,G,M,R,B,K: each channel is one inverted index bit.
            r = {COLW{~bar[1]}};
            g = {COLW{~bar[2]}};
            b = {COLW{~bar[0]}};
         end
         (mode_e == 3'd2): begin
            r = {COLW{x8[5] ^ y8[5]}};
            g = r;
            b = r;
         end
         (mode_e == 3'd3): begin
            r = ext(x8);
            g = ext(y8);
            b = ext(x8 ^ y8);
         end
         (mode_e == 3'd4): begin
            r = {COLW{in_sq}};
            g = {COLW{in_sq}};
            b = '1;
         end
         (mode_e == 3'd5): begin
            r = ext({x8[5:0] & {6{y8[4:3] == ~x8[4:3]}}, 2'b00});
            g = ext(x8 & {8{y8[6]}});
            b = ext(y8);
         end
         default: ;
      endcase
`ifdef VIDEO_PATTERN_BORDER_EN
      if ((mode_e inside {[3'd1:3'd5]}) &&
          (cx == '0 || cx == H_A - 1'b1 ||
           cy == '0 || cy == V_A - 1'b1)) begin
         r = '1;
         g = '1;
         b = '1;
      end
`endif
      if (!de_c) begin
         r = '0;
         g = '0;
         b = '0;
      end
   end

   always_ff @(posedge clk_pix or negedge rst_n) begin
      if (!rst_n) begin
         sx          <= '0;
         sy          <= '0;
         de          <= 1'b0;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         frame_start <= 1'b0;
         rgb         <= '0;
      end else begin
         sx          <= cx;
         sy          <= cy;
         de          <= de_c;
         hsync       <= hs_c ? HS_POL : ~HS_POL;
         vsync       <= vs_c ? VS_POL : ~VS_POL;
         frame_start <= origin;
         rgb         <= {r, g, b};
      end
   end

endmodule
